commit_trace_buffer: RTL and testbench

Synthesizable on-chip successor to the simulation-only commit logger of the 16-bit 5-stage pipelined CPU. Taps the writeback/memory-stage commit signals, timestamps every active cycle, and queues one packed trace record per active cycle in a parametrised FIFO. A host or JTAG drain engine reads records through a valid/ready port. Also keeps instruction/cycle statistics, a halt/timeout run-state machine, and overflow accounting.

---
 rtl/commit_trace_buffer.sv | 189 ++++++++++++++++++
 tb/tb_commit_trace_buffer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_buffer.sv
// Commit-trace capture: timestamps active commit cycles into a FIFO drained over valid/ready.
// Optional build macro TRACE_WRAP_EN: when full, overwrite the oldest record instead of dropping the newest.
module commit_trace_buffer #(
  parameter int DATA_W     = 16,
  parameter int RAW        = 4,
  parameter int DEPTH      = 16,
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 100000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     arm,
  input  logic [DATA_W-1:0]        pc,
  input  logic                     rf_we,
  input  logic [RAW-1:0]           rf_waddr,
  input  logic [DATA_W-1:0]        rf_wdata,
  input  logic                     mem_re,
  input  logic                     mem_we,
  input  logic [DATA_W-1:0]        mem_addr,
  input  logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     hlt,
  output logic                     rec_valid,
  input  logic                     rec_ready,
  output logic [3:0]               rec_flags,
  output logic [DATA_W-1:0]        rec_pc,
  output logic [RAW-1:0]           rec_reg,
  output logic [DATA_W-1:0]        rec_rdata,
  output logic [DATA_W-1:0]        rec_maddr,
  output logic [DATA_W-1:0]        rec_mdata,
  output logic [CNT_W-1:0]         rec_cycle,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         inst_count,
  output logic [CNT_W-1:0]         cycle_count,
  output logic [CNT_W-1:0]         drop_count,
  output logic                     overflow,
  output logic [1:0]               state,
  output logic                     timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]       FULL_LVL = DEPTH[AW:0];
  localparam logic [CNT_W-1:0]  MAX_LAST = CNT_W'(MAX_CYCLES - 1);
  localparam bit                TO_EN    = (MAX_CYCLES != 0);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_STOP = 2'd2, S_DONE = 2'd3} state_t;

  typedef struct packed {
    logic [3:0]        flags;
    logic [DATA_W-1:0] pc;
    logic [RAW-1:0]    waddr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] maddr;
    logic [DATA_W-1:0] mdata;
    logic [CNT_W-1:0]  cycle;
  } rec_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]       level_q, level_d;
  logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;
  logic [CNT_W-1:0]  inst_count_q, inst_count_d;
  logic [CNT_W-1:0]  drop_count_q, drop_count_d;
  logic              overflow_q, overflow_d;
  logic              timeout_q, timeout_d;
  rec_t              mem_q [DEPTH];
  rec_t              cap_rec, head_rec;
  logic              mem_wen, push, push_ok, pop, full;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    cap_rec = '{flags: {hlt, mem_we, mem_re, rf_we}, pc: pc, waddr: rf_waddr,
                wdata: rf_wdata, maddr: mem_addr,
                mdata: (mem_re ? mem_rdata : mem_wdata), cycle: cycle_count_q};
    full    = (level_q == FULL_LVL);
    pop     = (level_q != '0) && rec_ready;
    push    = (state_q == S_RUN) && (rf_we | mem_re | mem_we | hlt);
    push_ok = push && (!full || pop);

    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    level_d       = level_q;
    cycle_count_d = cycle_count_q;
    inst_count_d  = inst_count_q;
    drop_count_d  = drop_count_q;
    overflow_d    = overflow_q;
    timeout_d     = timeout_q;
    mem_wen       = 1'b0;

    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_ok) begin
      mem_wen  = 1'b1;
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else if (push) begin
      drop_count_d = sat_inc(drop_count_q);
      overflow_d   = 1'b1;
`ifdef TRACE_WRAP_EN
      // Full with no pop: wr_ptr equals rd_ptr, so this overwrites the oldest record.
      mem_wen  = 1'b1;
      wr_ptr_d = wr_ptr_q + AW'(1);
      rd_ptr_d = rd_ptr_q + AW'(1);
`endif
    end
    if (push_ok && !pop)      level_d = level_q + (AW+1)'(1);
    else if (!push_ok && pop) level_d = level_q - (AW+1)'(1);

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (arm) begin
          state_d       = S_RUN;
          wr_ptr_d      = '0;
          rd_ptr_d      = '0;
          level_d       = '0;
          cycle_count_d = '0;
          inst_count_d  = '0;
          drop_count_d  = '0;
          overflow_d    = 1'b0;
          timeout_d     = 1'b0;
          mem_wen       = 1'b0;
        end
      end
      S_RUN: begin
        cycle_count_d = sat_inc(cycle_count_q);
        if (hlt | rf_we | mem_we) inst_count_d = sat_inc(inst_count_q);
        // Halt takes priority over the cycle limit, leaving timeout clear.
        if (hlt) begin
          state_d = S_STOP;
        end else if (TO_EN && (cycle_count_q == MAX_LAST)) begin
          state_d   = S_STOP;
          timeout_d = 1'b1;
        end
      end
      S_STOP: begin
        if (level_q == '0) state_d = S_DONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      cycle_count_q <= '0;
      inst_count_q  <= '0;
      drop_count_q  <= '0;
      overflow_q    <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      cycle_count_q <= cycle_count_d;
      inst_count_q  <= inst_count_d;
      drop_count_q  <= drop_count_d;
      overflow_q    <= overflow_d;
      timeout_q     <= timeout_d;
    end
  end

  // Storage needs no reset: outputs are masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (mem_wen) mem_q[wr_ptr_q] <= cap_rec;
  end

  assign rec_valid   = (level_q != '0);
  assign head_rec    = rec_valid ? mem_q[rd_ptr_q] : '0;
  assign rec_flags   = head_rec.flags;
  assign rec_pc      = head_rec.pc;
  assign rec_reg     = head_rec.waddr;
  assign rec_rdata   = head_rec.wdata;
  assign rec_maddr   = head_rec.maddr;
  assign rec_mdata   = head_rec.mdata;
  assign rec_cycle   = head_rec.cycle;
  assign level       = level_q;
  assign inst_count  = inst_count_q;
  assign cycle_count = cycle_count_q;
  assign drop_count  = drop_count_q;
  assign overflow    = overflow_q;
  assign state       = state_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Randomized scoreboard bench for commit_trace_buffer built with MAX_CYCLES=50.
// A queue model of the trace contents feeds an independent monitor that checks every drained record.
`timescale 1ns/1ps
module tb_commit_trace_buffer;

  localparam int DATA_W = 16, RAW = 4, DEPTH = 16, CNT_W = 32, MAX_CYCLES = 50;

  logic              clk = 1'b0, rst_n = 1'b0, arm = 1'b0;
  logic [DATA_W-1:0] pc = '0, rf_wdata = '0, mem_addr = '0, mem_wdata = '0, mem_rdata = '0;
  logic [RAW-1:0]    rf_waddr = '0;
  logic              rf_we = 1'b0, mem_re = 1'b0, mem_we = 1'b0, hlt = 1'b0, rec_ready = 1'b0;
  logic              rec_valid, overflow, timeout;
  logic [3:0]        rec_flags;
  logic [DATA_W-1:0] rec_pc, rec_rdata, rec_maddr, rec_mdata;
  logic [RAW-1:0]    rec_reg;
  logic [CNT_W-1:0]  rec_cycle, inst_count, cycle_count, drop_count;
  logic [$clog2(DEPTH):0] level;
  logic [1:0]        state;

  commit_trace_buffer #(.DATA_W(DATA_W), .RAW(RAW), .DEPTH(DEPTH), .CNT_W(CNT_W),
                        .MAX_CYCLES(MAX_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .pc(pc), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .hlt(hlt), .rec_valid(rec_valid),
    .rec_ready(rec_ready), .rec_flags(rec_flags), .rec_pc(rec_pc), .rec_reg(rec_reg),
    .rec_rdata(rec_rdata), .rec_maddr(rec_maddr), .rec_mdata(rec_mdata),
    .rec_cycle(rec_cycle), .level(level), .inst_count(inst_count),
    .cycle_count(cycle_count), .drop_count(drop_count), .overflow(overflow),
    .state(state), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  flags;
    logic [15:0] pc;
    logic [3:0]  rg;
    logic [15:0] rdata;
    logic [15:0] maddr;
    logic [15:0] mdata;
    logic [31:0] cyc;
  } rec_t;

  rec_t exp_q[$];
  int   total = 0, bad = 0;
  int   m_state = 0, m_cycle = 0, m_inst = 0, m_drop = 0;
  bit   m_ovf = 0, m_to = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and advance the model by the same rules.
  task automatic applyStimulus(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                               input logic re, input logic mw, input logic [15:0] ma,
                               input logic [15:0] mwd, input logic [15:0] mrd,
                               input logic h, input logic rdy);
    rec_t r;
    bit   pop_now;
    @(negedge clk);
    arm = 1'b0; pc = 16'($urandom); rf_we = we; rf_waddr = wa; rf_wdata = wd;
    mem_re = re; mem_we = mw; mem_addr = ma; mem_wdata = mwd; mem_rdata = mrd;
    hlt = h; rec_ready = rdy;
    if (m_state == 1) begin
      if (we || re || mw || h) begin
        r.flags = {h, mw, re, we}; r.pc = pc; r.rg = wa; r.rdata = wd;
        r.maddr = ma; r.mdata = re ? mrd : mwd; r.cyc = m_cycle;
        pop_now = rdy && (exp_q.size() > 0);
        if (exp_q.size() < DEPTH || pop_now) exp_q.push_back(r);
        else begin
          m_drop++; m_ovf = 1;
`ifdef TRACE_WRAP_EN
          exp_q.delete(0);
          exp_q.push_back(r);
`endif
        end
      end
      if (h || we || mw) m_inst++;
      if (h) m_state = 2;
      else if (m_cycle == MAX_CYCLES - 1) begin m_state = 2; m_to = 1; end
      m_cycle++;
    end
    @(posedge clk); #1;
  endtask

  task automatic idleStep(input logic rdy);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, rdy);
  endtask

  task automatic randStep(input int hchance, input bit force_we, input logic rdy);
    logic we, re, mw, h;
    we = force_we || ($urandom_range(0, 2) == 0);
    re = ($urandom_range(0, 3) == 0);
    mw = ($urandom_range(0, 3) == 0);
    h  = (hchance > 0) && ($urandom_range(0, hchance) == 0);
    applyStimulus(we, 4'($urandom), 16'($urandom), re, mw, 16'($urandom),
                  16'($urandom), 16'($urandom), h, rdy);
  endtask

  task automatic armRun();
    @(negedge clk);
    arm = 1'b1; rf_we = 0; mem_re = 0; mem_we = 0; hlt = 0; rec_ready = 0;
    exp_q.delete();
    m_state = 1; m_cycle = 0; m_inst = 0; m_drop = 0; m_ovf = 0; m_to = 0;
  endtask

  task automatic checkRunEnd(input string tag);
    checkOutput({tag, "_state_stop"}, state, 2);
    checkOutput({tag, "_inst"}, inst_count, m_inst);
    checkOutput({tag, "_cycles"}, cycle_count, m_cycle);
    checkOutput({tag, "_drops"}, drop_count, m_drop);
    checkOutput({tag, "_overflow"}, overflow, m_ovf);
    checkOutput({tag, "_timeout"}, timeout, m_to);
  endtask

  task automatic drainRun(input string tag);
    int n = 0;
    while (state !== 2'd3 && n < 200) begin
      idleStep(logic'($urandom_range(0, 1)));
      n++;
    end
    checkOutput({tag, "_drain_done"}, state, 3);
    checkOutput({tag, "_drain_level"}, level, 0);
    checkOutput({tag, "_drain_leftover"}, exp_q.size(), 0);
    checkOutput({tag, "_inst_frozen"}, inst_count, m_inst);
    m_state = 3;
  endtask

  task automatic resetDut(input string tag);
    @(negedge clk);
    rst_n = 1'b0; arm = 0; rf_we = 0; mem_re = 0; mem_we = 0; hlt = 0; rec_ready = 0;
    @(posedge clk); #1;
    checkOutput({tag, "_state"}, state, 0);
    checkOutput({tag, "_level"}, level, 0);
    checkOutput({tag, "_valid"}, rec_valid, 0);
    checkOutput({tag, "_rec_cycle"}, rec_cycle, 0);
    checkOutput({tag, "_rec_pc"}, rec_pc, 0);
    checkOutput({tag, "_counts"}, {inst_count, cycle_count}, 0);
    checkOutput({tag, "_drops"}, drop_count, 0);
    checkOutput({tag, "_flags"}, {overflow, timeout}, 0);
    exp_q.delete();
    m_state = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: every accepted record must match the oldest expected one.
  initial begin
    rec_t e;
    forever begin
      @(negedge clk); #3;
      if (rst_n && rec_valid && rec_ready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL unexpected_rec: got cycle 0x%0h expected no record", rec_cycle);
        end else begin
          e = exp_q.pop_front();
          checkOutput("rec_flags", rec_flags, e.flags);
          checkOutput("rec_pc", rec_pc, e.pc);
          checkOutput("rec_reg", rec_reg, e.rg);
          checkOutput("rec_rdata", rec_rdata, e.rdata);
          checkOutput("rec_maddr", rec_maddr, e.maddr);
          checkOutput("rec_mdata", rec_mdata, e.mdata);
          checkOutput("rec_cycle", rec_cycle, e.cyc);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    resetDut("reset");

    $display("[TB] directed capture");
    armRun();
    idleStep(0);
    idleStep(0);
    checkOutput("valid_before", rec_valid, 0);
    applyStimulus(1, 4'd3, 16'h00AA, 0, 0, 16'h0, 16'h0, 16'h0, 0, 0);
    checkOutput("valid_latency", rec_valid, 1);
    checkOutput("first_cycle", rec_cycle, 2);
    checkOutput("first_flags", rec_flags, 4'b0001);
    checkOutput("inst_one", inst_count, 1);
    applyStimulus(1, 4'd1, 16'h1234, 0, 1, 16'h0040, 16'h5555, 16'h0, 0, 1);
    applyStimulus(0, 4'd0, 16'h0, 1, 0, 16'h0080, 16'h0, 16'hBEEF, 0, 1);
    checkOutput("inst_mem_re", inst_count, 2);
    applyStimulus(0, 4'd0, 16'h0, 0, 0, 16'h0, 16'h0, 16'h0, 1, 0);
    checkRunEnd("capture");
    drainRun("capture");

    $display("[TB] overflow");
    armRun();
    repeat (20) randStep(0, 1, 0);
    checkOutput("ovf_level", level, DEPTH);
    checkOutput("ovf_drops", drop_count, 4);
    checkOutput("ovf_flag", overflow, 1);
    randStep(0, 1, 1);
    checkOutput("fullpushpop_drops", drop_count, 4);
    checkOutput("fullpushpop_level", level, DEPTH);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    checkRunEnd("overflow");
    drainRun("overflow");

    $display("[TB] halt with queued records");
    armRun();
    for (int c = 0; c < 7; c++) begin
      if (c % 2 == 1) randStep(0, 1, 0);
      else idleStep(0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    checkRunEnd("halt");
    checkOutput("halt_level", level, 4);
    idleStep(0);
    checkOutput("halt_cycles_frozen", cycle_count, 8);
    drainRun("halt");

    $display("[TB] timeout");
    armRun();
    n = 0;
    while (m_state == 1 && n < 60) begin randStep(0, 0, logic'($urandom_range(0, 1))); n++; end
    checkRunEnd("timeout");
    checkOutput("timeout_cycle_count", cycle_count, MAX_CYCLES);
    drainRun("timeout");

    $display("[TB] random runs");
    for (int run = 0; run < 8; run++) begin
      armRun();
      n = 0;
      while (m_state == 1 && n < 60) begin
        randStep(25, 0, logic'($urandom_range(0, 3) == 0));
        n++;
      end
      checkRunEnd("random");
      drainRun("random");
    end

    $display("[TB] reset mid-run");
    armRun();
    repeat (10) randStep(0, 1, 0);
    resetDut("midreset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
